// File: rtl/jump_pkg.sv
// Jump-interface encodings shared by the jump controller and the height/sprite consumer.
// Latency: n/a (constants and types only); backpressure: n/a.
package jump_pkg;

  localparam int H_W = 8;

  localparam logic [1:0] JS_IDLE = 2'b00;
  localparam logic [1:0] JS_RISE = 2'b01;
  localparam logic [1:0] JS_FALL = 2'b10;
  localparam logic [1:0] JS_HANG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = JS_IDLE,
    ST_RISE = JS_RISE,
    ST_FALL = JS_FALL,
    ST_HANG = JS_HANG
  } jstate_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse for a raw button.
// Latency: press pulses 3 clk edges after the button rises; no backpressure.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      press <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Turns the jump button into a tick-stepped jump state and height, with apex hang and a one-deep press buffer.
// Latency: changes land one clk after a tick cycle; no backpressure, run=0 freezes all motion and drops presses.
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int TICK_DIV   = 2_500_000,
  parameter int STEP       = 50,
  parameter int H_MAX      = 200,
  parameter int HANG_TICKS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_jump,
  input  logic           run,
  output logic [1:0]     jumpstate,
  output logic [H_W-1:0] hnow,
  output logic           airborne,
  output logic           landed,
  output logic [15:0]    jump_cnt
);

  localparam int             DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [H_W-1:0] STEP_H   = H_W'(STEP);
  localparam logic [H_W-1:0] HMAX_H   = H_W'(H_MAX);
  localparam logic [7:0]     HANG_N   = 8'(HANG_TICKS);

  jstate_t        state, state_nx;
  logic [DW-1:0]  div_cnt;
  logic           tick, press, press_ok, pending, pend_eff;
  logic [7:0]     hang_cnt, hang_nx;
  logic [H_W-1:0] h_nx;
  logic [H_W:0]   h_sum;
  logic           start, land;

  btn_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_jump),
    .press (press)
  );

  assign tick      = run && (div_cnt == DIV_LAST);
  assign press_ok  = press && run && (state == ST_IDLE || state == ST_FALL);
  // A press arriving on the tick cycle itself may launch from IDLE immediately.
  assign pend_eff  = pending | press_ok;
  assign h_sum     = {1'b0, hnow} + {1'b0, STEP_H};
  assign jumpstate = state;

  always_comb begin
    state_nx = state;
    h_nx     = hnow;
    hang_nx  = hang_cnt;
    start    = 1'b0;
    land     = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (pend_eff) begin
            state_nx = ST_RISE;
            h_nx     = STEP_H;
            start    = 1'b1;
          end else begin
            h_nx = '0;
          end
        end
        ST_RISE: begin
          if (hnow == HMAX_H)
            state_nx = (HANG_TICKS > 0) ? ST_HANG : ST_FALL;
          else if (h_sum > {1'b0, HMAX_H})
            h_nx = HMAX_H;
          else
            h_nx = h_sum[H_W-1:0];
        end
        ST_HANG: begin
          if (hang_cnt + 8'd1 == HANG_N) begin
            state_nx = ST_FALL;
            hang_nx  = '0;
          end else begin
            hang_nx = hang_cnt + 8'd1;
          end
        end
        ST_FALL: begin
          if (hnow == '0) begin
            state_nx = ST_IDLE;
            land     = 1'b1;
          end else if (hnow <= STEP_H) begin
            h_nx = '0;
          end else begin
            h_nx = hnow - STEP_H;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hnow     <= '0;
      airborne <= 1'b0;
      landed   <= 1'b0;
      jump_cnt <= '0;
      div_cnt  <= '0;
      hang_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nx;
      hnow     <= h_nx;
      hang_cnt <= hang_nx;
      airborne <= (state_nx != ST_IDLE);
      landed   <= land;
      if (start)
        jump_cnt <= jump_cnt + 16'd1;
      if (run)
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (start)
        pending <= 1'b0;
      else if (press_ok)
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl with a 4-clk tick; one DUT with apex hang, one without.
// Latency: each group() call spans exactly one tick and samples on the falling edge after it.
// Backpressure: none; stimulus is driven open-loop and every mismatch is counted in n_fail.
module tb_jump_ctrl;

    logic        clk = 1'b0;
    logic        rst, btn, btn0, run;
    logic [1:0]  js, js0;
    logic [7:0]  h, h0;
    logic        ab, ab0, ld, ld0;
    logic [15:0] jc, jc0;
    int          n_run = 0;
    int          n_fail = 0;

    // Hand-derived single-jump trace for STEP=50, H_MAX=200, HANG_TICKS=2.
    localparam logic [1:0] ES [12] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3,
                                       2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    localparam logic [7:0] EH [12] = '{8'd50, 8'd100, 8'd150, 8'd200, 8'd200, 8'd200,
                                       8'd200, 8'd150, 8'd100, 8'd50, 8'd0, 8'd0};

    always #5 clk = ~clk;

    jump_ctrl #(.TICK_DIV(4), .STEP(50), .H_MAX(200), .HANG_TICKS(2)) dut (
        .clk(clk), .rst(rst), .btn_jump(btn), .run(run),
        .jumpstate(js), .hnow(h), .airborne(ab), .landed(ld), .jump_cnt(jc)
    );

    jump_ctrl #(.TICK_DIV(4), .STEP(60), .H_MAX(180), .HANG_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .btn_jump(btn0), .run(run),
        .jumpstate(js0), .hnow(h0), .airborne(ab0), .landed(ld0), .jump_cnt(jc0)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = 1'b0; btn0 = 1'b0; run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One tick period; an optional press starts at the group boundary.
    task automatic group(input logic p, input logic p0);
        btn = p; btn0 = p0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn = 1'b0; btn0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if ({js, h, ab, ld, jc} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset: js=%b h=%0d ab=%b ld=%b jc=%0d, expected all zero", js, h, ab, ld, jc);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); @(negedge clk);
            n_run++;
            if ({js, h, ld} !== 11'd0) begin
                n_fail++;
                $display("FAIL idle c%0d: js=%b h=%0d ld=%b, expected 00/0/0", c, js, h, ld);
            end
        end
        n_run++;
        if (jc !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_cnt: jc=%0d, expected 0", jc);
        end
    endtask

    task automatic test_single_jump();
        logic exp_ld, exp_ab;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            group(i == 0, 1'b0);
            exp_ld = (i == 11);
            exp_ab = (ES[i] != 2'd0);
            n_run++;
            if ({js, h, ld, ab} !== {ES[i], EH[i], exp_ld, exp_ab}) begin
                n_fail++;
                $display("FAIL single t%0d: js=%b h=%0d ld=%b ab=%b, expected %b/%0d/%b/%b",
                         i + 1, js, h, ld, ab, ES[i], EH[i], exp_ld, exp_ab);
            end
        end
        n_run++;
        if (jc !== 16'd1) begin
            n_fail++;
            $display("FAIL single_cnt: jc=%0d, expected 1", jc);
        end
    endtask

    task automatic test_rise_press_ignored();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            group(i <= 1, 1'b0);
            if (i == 12) begin
                n_run++;
                if ({js, h, ld} !== 11'd0) begin
                    n_fail++;
                    $display("FAIL rise_press t13: js=%b h=%0d ld=%b, expected 00/0/0", js, h, ld);
                end
            end else begin
                n_run++;
                if ({js, h} !== {ES[i], EH[i]}) begin
                    n_fail++;
                    $display("FAIL rise_press t%0d: js=%b h=%0d, expected %b/%0d", i + 1, js, h, ES[i], EH[i]);
                end
            end
        end
        n_run++;
        if (jc !== 16'd1) begin
            n_fail++;
            $display("FAIL rise_press_cnt: jc=%0d, expected 1", jc);
        end
    endtask

    task automatic test_buffered();
        do_reset();
        // Second press lands while falling at height 100.
        for (int i = 0; i < 12; i++) begin
            group(i == 0 || i == 9, 1'b0);
            n_run++;
            if ({js, h, ld} !== {ES[i], EH[i], (i == 11)}) begin
                n_fail++;
                $display("FAIL buffered t%0d: js=%b h=%0d ld=%b, expected %b/%0d/%b",
                         i + 1, js, h, ld, ES[i], EH[i], (i == 11));
            end
        end
        group(1'b0, 1'b0);
        n_run++;
        if ({js, h, ld, jc} !== {2'b01, 8'd50, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL buffered_relaunch: js=%b h=%0d ld=%b jc=%0d, expected 01/50/0/2", js, h, ld, jc);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 3; i++) group(i == 0, 1'b0);
        run = 1'b0;
        for (int c = 0; c < 20; c++) begin
            btn = ((c % 6) < 3);
            @(posedge clk); @(negedge clk);
            n_run++;
            if ({js, h} !== {2'b01, 8'd150}) begin
                n_fail++;
                $display("FAIL freeze c%0d: js=%b h=%0d, expected 01/150", c, js, h);
            end
        end
        btn = 1'b0;
        run = 1'b1;
        for (int i = 3; i < 13; i++) begin
            group(1'b0, 1'b0);
            if (i == 12) begin
                n_run++;
                if ({js, h, ld} !== 11'd0) begin
                    n_fail++;
                    $display("FAIL freeze_after t13: js=%b h=%0d ld=%b, expected 00/0/0", js, h, ld);
                end
            end else begin
                n_run++;
                if ({js, h, ld} !== {ES[i], EH[i], (i == 11)}) begin
                    n_fail++;
                    $display("FAIL freeze_resume t%0d: js=%b h=%0d ld=%b, expected %b/%0d/%b",
                             i + 1, js, h, ld, ES[i], EH[i], (i == 11));
                end
            end
        end
        n_run++;
        if (jc !== 16'd1) begin
            n_fail++;
            $display("FAIL freeze_cnt: jc=%0d, expected 1", jc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) group(i == 0, 1'b0);
        n_run++;
        if (js !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pre: js=%b, expected 11", js);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_run++;
        if ({js, h, ld, ab, jc} !== 28'd0) begin
            n_fail++;
            $display("FAIL mid_reset: js=%b h=%0d ld=%b ab=%b jc=%0d, expected all zero", js, h, ld, ab, jc);
        end
        // Reset with a press buffered during FALL must drop it.
        do_reset();
        for (int i = 0; i < 10; i++) group(i == 0 || i == 9, 1'b0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            group(1'b0, 1'b0);
            n_run++;
            if ({js, h, jc} !== 26'd0) begin
                n_fail++;
                $display("FAIL mid_pending t%0d: js=%b h=%0d jc=%0d, expected 00/0/0", i + 1, js, h, jc);
            end
        end
    endtask

    task automatic test_no_hang();
        logic [1:0] es0 [8];
        logic [7:0] eh0 [8];
        es0 = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        eh0 = '{8'd60, 8'd120, 8'd180, 8'd180, 8'd120, 8'd60, 8'd0, 8'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            group(1'b0, i == 0);
            n_run++;
            if ({js0, h0, ld0, ab0} !== {es0[i], eh0[i], (i == 7), (i != 7)}) begin
                n_fail++;
                $display("FAIL nohang t%0d: js=%b h=%0d ld=%b ab=%b, expected %b/%0d/%b/%b",
                         i + 1, js0, h0, ld0, ab0, es0[i], eh0[i], (i == 7), (i != 7));
            end
        end
        n_run++;
        if (jc0 !== 16'd1) begin
            n_fail++;
            $display("FAIL nohang_cnt: jc=%0d, expected 1", jc0);
        end
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; btn0 = 1'b0; run = 1'b1;
        test_reset();
        test_single_jump();
        test_rise_press_ignored();
        test_buffered();
        test_freeze();
        test_reset_mid();
        test_no_hang();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Initiator side of the jump interface: converts the player's jump button into the 2-bit jump-state code and a stepped height value.
- Sits between the input sampling logic and the sprite/collision logic; the consumer reads jumpstate and hnow.
- Owns the game-tick divider, the height register, an apex hang phase, and a one-deep press buffer.

Parameters:
- TICK_DIV, 2_500_000, clk cycles per motion tick (must be >= 2)
- STEP, 50, height change per tick while rising or falling
- H_MAX, 200, apex height (must be a multiple of STEP, and <= 255)
- HANG_TICKS, 2, ticks held at apex before falling (0 = no hang)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_jump  in  1  raw asynchronous jump button, active-high
- run  in  1  1 = game running; 0 = freeze everything
- jumpstate  out  2  00 idle, 01 rising, 10 falling, 11 hang at apex
- hnow  out  8  current height, 0..H_MAX
- airborne  out  1  1 whenever jumpstate != 00
- landed  out  1  one-clk pulse on the FALL->IDLE transition
- jump_cnt  out  16  jumps started since reset, wraps at 16 bits

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1 at a clk edge, all of the following clear:
  - state IDLE, hnow=0, airborne=0, landed=0, jump_cnt=0
  - divider=0, hang counter=0, pending=0, synchroniser flops=0
- Reset mid-jump clears to ground immediately. No landed pulse is produced.
- Button input:
  - btn_jump passes through a 2-flop synchroniser, then a rising-edge detector.
  - press = a 1-clk pulse, 3 clk edges after the button rises.
- Divider:
  - When run=1, the divider counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where count == TICK_DIV-1.
  - When run=0, the divider holds, no tick occurs, and presses are discarded.
- Pending flag:
  - Set by press when state is IDLE or FALL.
  - A press in RISE or HANG is ignored.
  - Multiple presses leave pending=1 (no count).
  - Cleared when a jump starts.
- All state and height changes occur only on a tick cycle, registered at the next clk edge.
- IDLE: if pending, go to RISE, hnow=STEP, jump_cnt+1, pending=0. Otherwise hold at hnow=0.
- RISE:
  - If hnow==H_MAX: go to HANG when HANG_TICKS>0, else FALL. hnow is unchanged on this tick.
  - Otherwise hnow = min(hnow+STEP, H_MAX).
- HANG:
  - The hang counter increments each tick.
  - On the tick where the counter reaches HANG_TICKS, go to FALL and clear the counter.
  - hnow is held.
- FALL:
  - If hnow==0: go to IDLE and assert landed for that one clk.
  - Otherwise hnow = (hnow<=STEP) ? 0 : hnow-STEP.
- Full jump with defaults takes 12 ticks: 4 up, 1 apex detect, 2 hang, 4 down, 1 ground detect.
- A press buffered during FALL launches on the first tick after landing, i.e. the tick following the landed pulse.
- A press and a tick in the same cycle: the press is latched first, and that same tick may start the jump from IDLE.
- Outputs are registered. jumpstate is the state encoding itself. airborne = (state != IDLE), registered.

Decomposition:
- Package jump_pkg holds:
  - localparams JS_IDLE=2'b00, JS_RISE=2'b01, JS_FALL=2'b10, JS_HANG=2'b11
  - H_W=8
  - These are shared with the height/sprite consumer.
- One sub-module: btn_sync_edge, containing the 2-flop synchroniser and the rising-edge pulse, reused for other buttons.
- Divider, FSM, height and counters stay in jump_ctrl.

Test Plan:
- Test parameters: TICK_DIV=4, STEP=50, H_MAX=200, HANG_TICKS=2.
- Reset then idle: rst for 2 clk, then 40 clk with no press -> jumpstate=00, hnow=0, landed never 1, jump_cnt=0.
- Single jump: one press -> at successive ticks hnow = 50,100,150,200,200(->11),200,200(->10),150,100,50,0,0. landed pulses once on the 00 transition; jump_cnt=1.
- Buffered press: press during FALL at hnow=100 -> landed pulse, then the next tick shows jumpstate=01, hnow=50, jump_cnt=2. A press during RISE gives no relaunch.
- Freeze: drop run at hnow=150 rising for 20 clk, pressing during the freeze -> hnow and jumpstate constant; after run=1 the jump resumes at 200 with no extra jump queued.
- Reset mid-jump: assert rst while jumpstate=11 -> next clk hnow=0, jumpstate=00, landed=0, jump_cnt=0, pending cleared.
- HANG_TICKS=0, STEP=60, H_MAX=180 -> heights 60,120,180,180(->10),120,60,0,0 (->00), with no 11 state ever seen.
